// File: rtl/val2_shifter_pipe.sv
// ============================================================================
// Module      : val2_shifter_pipe
// Description : Two-stage pipelined operand-2 generator for the execute stage.
//               S1 registers the request and folds every operand type into a
//               single (operand, shift type, amount) triple. S2 runs a unified
//               barrel shifter and registers val_2 / carry_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module val2_shifter_pipe #(
  parameter int DATA_W = 32,
  parameter int LOG_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm,
  input  logic              mem_sel,
  input  logic              reg_shift,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] rm,
  input  logic [7:0]        rs,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val_2,
  output logic              carry_out
);

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;
  // Full-width amount used when an immediate amount of 0 encodes "shift by DATA_W".
  localparam logic [7:0] AMT_FULL = 8'(DATA_W);

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv, s1_adv, accept;

  // S1 payload: resolved operand, shift type, amount, RRX flag and sampled carry
  logic [DATA_W-1:0] s1_opnd_q, s1_opnd_d;
  logic [1:0]        s1_sh_q,   s1_sh_d;
  logic [7:0]        s1_amt_q,  s1_amt_d;
  logic              s1_rrx_q,  s1_rrx_d;
  logic              s1_cin_q;

  // S2 result
  logic [DATA_W-1:0] val_q, val_d;
  logic              carry_q, carry_d;

  // Shifter intermediates: the extra bit captures the last bit shifted out
  logic [DATA_W:0]   lsl_ext, lsr_ext, asr_ext;
  logic [LOG_W-1:0]  ror_amt;
  logic [DATA_W-1:0] ror_val;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = s1_valid_q && s2_adv;
  assign in_ready  = !flush && (!s1_valid_q || s2_adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid_q;
  assign val_2     = val_q;
  assign carry_out = carry_q;

  // Valid next-state: flush wins over any accept or advance
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)      s1_valid_d = 1'b1;
      else if (s1_adv) s1_valid_d = 1'b0;
      if (s1_adv)         s2_valid_d = 1'b1;
      else if (out_ready) s2_valid_d = 1'b0;
    end
  end

  // Decode: map every operand type onto operand/type/amount so S2 needs one shifter.
  // Rotated immediate becomes ROR of the zero-extended byte, memory offset becomes
  // LSL #0 (passes operand and carry_in), immediate #0 encodings become DATA_W or RRX.
  always_comb begin
    s1_opnd_d = rm;
    s1_sh_d   = shift_operand[6:5];
    s1_amt_d  = {3'b000, shift_operand[11:7]};
    s1_rrx_d  = 1'b0;
    if (mem_sel) begin
      s1_opnd_d = DATA_W'(shift_operand);
      s1_sh_d   = SH_LSL;
      s1_amt_d  = 8'd0;
    end else if (imm) begin
      s1_opnd_d = DATA_W'(shift_operand[7:0]);
      s1_sh_d   = SH_ROR;
      s1_amt_d  = {3'b000, shift_operand[11:8], 1'b0};
    end else if (reg_shift) begin
      s1_amt_d  = rs;
    end else if (shift_operand[11:7] == 5'd0) begin
      case (shift_operand[6:5])
        SH_LSR, SH_ASR: s1_amt_d = AMT_FULL;
        SH_ROR:         s1_rrx_d = 1'b1;
        default:        s1_amt_d = 8'd0;
      endcase
    end
  end

  // Stage-1 registers: valid bits always move, payload loads only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_opnd_q  <= '0;
      s1_sh_q    <= 2'd0;
      s1_amt_q   <= 8'd0;
      s1_rrx_q   <= 1'b0;
      s1_cin_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_opnd_q <= s1_opnd_d;
        s1_sh_q   <= s1_sh_d;
        s1_amt_q  <= s1_amt_d;
        s1_rrx_q  <= s1_rrx_d;
        s1_cin_q  <= carry_in;
      end
    end
  end

  // Unified shifter: out-of-range amounts naturally produce 0 / sign fill,
  // and the guard bit of each extended shift is the carry.
  always_comb begin
    lsl_ext = {1'b0, s1_opnd_q} << s1_amt_q;
    lsr_ext = {s1_opnd_q, 1'b0} >> s1_amt_q;
    asr_ext = $signed({s1_opnd_q, 1'b0}) >>> s1_amt_q;
    ror_amt = s1_amt_q[LOG_W-1:0];
    ror_val = (s1_opnd_q >> ror_amt) | (s1_opnd_q << (DATA_W - int'(ror_amt)));
    val_d   = s1_opnd_q;
    carry_d = s1_cin_q;
    if (s1_rrx_q) begin
      val_d   = {s1_cin_q, s1_opnd_q[DATA_W-1:1]};
      carry_d = s1_opnd_q[0];
    end else if (s1_amt_q != 8'd0) begin
      case (s1_sh_q)
        SH_LSL:  {carry_d, val_d} = lsl_ext;
        SH_LSR:  {val_d, carry_d} = lsr_ext;
        SH_ASR:  {val_d, carry_d} = asr_ext;
        default: begin
          val_d   = ror_val;
          carry_d = ror_val[DATA_W-1];
        end
      endcase
    end
  end

  // Stage-2 registers: result holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= '0;
      carry_q <= 1'b0;
    end else if (s1_adv && !flush) begin
      val_q   <= val_d;
      carry_q <= carry_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_val2_shifter_pipe.sv
// ============================================================================
// Module      : tb_val2_shifter_pipe
// Description : Self-checking bench driving a 32-bit and a 64-bit instance with
//               shared stimulus; results compared against a bit-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_val2_shifter_pipe;

  typedef struct {
    logic        mem;
    logic        imm;
    logic        rg;
    logic [11:0] so;
    logic [63:0] rm;
    logic [7:0]  rs;
    logic        cin;
  } req_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        imm, mem_sel, reg_shift, carry_in;
  logic [11:0] shift_operand;
  logic [63:0] rm;
  logic [7:0]  rs;
  logic        in_ready32, out_valid32, carry32;
  logic [31:0] val32;
  logic        in_ready64, out_valid64, carry64;
  logic [63:0] val64;

  int total = 0;
  int bad   = 0;

  req_t         req_q[$];
  logic [64:0]  exp32_q[$];
  logic [64:0]  exp64_q[$];

  always #5 clk = ~clk;

  val2_shifter_pipe #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .imm(imm), .mem_sel(mem_sel), .reg_shift(reg_shift), .shift_operand(shift_operand),
    .rm(rm[31:0]), .rs(rs), .carry_in(carry_in), .out_valid(out_valid32),
    .out_ready(out_ready), .val_2(val32), .carry_out(carry32)
  );

  val2_shifter_pipe #(.DATA_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .imm(imm), .mem_sel(mem_sel), .reg_shift(reg_shift), .shift_operand(shift_operand),
    .rm(rm), .rs(rs), .carry_in(carry_in), .out_valid(out_valid64),
    .out_ready(out_ready), .val_2(val64), .carry_out(carry64)
  );

  // ---------------- reference model (bit-by-bit, from the operand rules) ----
  function automatic logic [63:0] f_lsl(input int w, input logic [63:0] x, input int n);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < w; k++) if (k - n >= 0) v[k] = x[k-n];
    return v;
  endfunction

  function automatic logic [63:0] f_lsr(input int w, input logic [63:0] x, input int n);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < w; k++) if (k + n < w) v[k] = x[k+n];
    return v;
  endfunction

  function automatic logic [63:0] f_asr(input int w, input logic [63:0] x, input int n);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < w; k++) v[k] = (k + n < w) ? x[k+n] : x[w-1];
    return v;
  endfunction

  function automatic logic [63:0] f_ror(input int w, input logic [63:0] x, input int n);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < w; k++) v[k] = x[(k + n) % w];
    return v;
  endfunction

  // returns {carry, value}
  function automatic logic [64:0] model(input int w, input req_t r);
    logic [63:0] x, v;
    logic        co, msb;
    int          a, n;
    logic [1:0]  sh;
    x   = (w == 64) ? r.rm : (r.rm & ((64'd1 << w) - 64'd1));
    msb = x[w-1];
    sh  = r.so[6:5];
    a   = int'(r.so[11:7]);
    v   = '0;
    co  = r.cin;
    if (r.mem) begin
      v  = 64'(r.so);
      co = r.cin;
    end else if (r.imm) begin
      n  = 2 * int'(r.so[11:8]);
      v  = f_ror(w, 64'(r.so[7:0]), n % w);
      co = (n == 0) ? r.cin : v[w-1];
    end else if (r.rg || a >= w) begin
      n = r.rg ? int'(r.rs) : a;
      if (n == 0) begin
        v = x; co = r.cin;
      end else begin
        case (sh)
          2'd0: begin
            if (n < w)       begin v = f_lsl(w, x, n); co = x[w-n]; end
            else if (n == w) begin v = '0; co = x[0]; end
            else             begin v = '0; co = 1'b0; end
          end
          2'd1: begin
            if (n < w)       begin v = f_lsr(w, x, n); co = x[n-1]; end
            else if (n == w) begin v = '0; co = msb; end
            else             begin v = '0; co = 1'b0; end
          end
          2'd2: begin
            if (n >= w) begin v = f_asr(w, x, w); co = msb; end
            else        begin v = f_asr(w, x, n); co = x[n-1]; end
          end
          default: begin
            if (n % w == 0) begin v = x; co = msb; end
            else begin v = f_ror(w, x, n % w); co = v[w-1]; end
          end
        endcase
      end
    end else begin
      case (sh)
        2'd0: begin
          if (a == 0) begin v = x; co = r.cin; end
          else begin v = f_lsl(w, x, a); co = x[w-a]; end
        end
        2'd1: begin
          if (a == 0) begin v = '0; co = msb; end
          else begin v = f_lsr(w, x, a); co = x[a-1]; end
        end
        2'd2: begin
          if (a == 0) begin v = f_asr(w, x, w); co = msb; end
          else begin v = f_asr(w, x, a); co = x[a-1]; end
        end
        default: begin
          if (a == 0) begin v = (x >> 1) | (64'(r.cin) << (w - 1)); co = x[0]; end
          else begin v = f_ror(w, x, a % w); co = v[w-1]; end
        end
      endcase
    end
    return {co, v};
  endfunction

  // ---------------- helpers --------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input req_t r);
    mem_sel       = r.mem;
    imm           = r.imm;
    reg_shift     = r.rg;
    shift_operand = r.so;
    rm            = r.rm;
    rs            = r.rs;
    carry_in      = r.cin;
  endtask

  function automatic req_t mk(input logic m, input logic i, input logic g, input logic [11:0] so,
                              input logic [63:0] x, input logic [7:0] s, input logic c);
    req_t r;
    r.mem = m; r.imm = i; r.rg = g; r.so = so; r.rm = x; r.rs = s; r.cin = c;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    int   p;
    p     = int'($urandom_range(0, 7));
    r.mem = (p == 0);
    r.imm = (p <= 2);
    r.rg  = 1'($urandom_range(0, 1));
    r.so  = 12'($urandom);
    if ($urandom_range(0, 3) == 0) r.so[11:7] = 5'd0;
    r.rm  = {$urandom, $urandom};
    r.cin = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       r.rs = 8'($urandom);
      1:       r.rs = 8'($urandom_range(0, 2));
      default: r.rs = 8'(32 * $urandom_range(1, 2) + $urandom_range(0, 2) - 1);
    endcase
    return r;
  endfunction

  // Single request on an idle pipe; checks fixed latency, constants and the model.
  // Called and returns at posedge+1.
  task automatic single(input string tag, input req_t r, input logic [31:0] ev32, input logic ec32,
                        input bit use64, input logic [63:0] ev64, input logic ec64);
    logic [64:0] m32, m64;
    m32 = model(32, r);
    m64 = model(64, r);
    drive(r);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_inrdy"}, 64'(in_ready32), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid32), 64'd0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, 64'(out_valid32), 64'd1);
    check({tag, "_v32"}, 64'(val32), 64'(ev32));
    check({tag, "_c32"}, 64'(carry32), 64'(ec32));
    check({tag, "_m32"}, {31'd0, carry32, val32}, m32[63:0] | (64'(m32[64]) << 32));
    check({tag, "_ov64"}, 64'(out_valid64), 64'd1);
    check({tag, "_v64"}, val64, m64[63:0]);
    check({tag, "_c64"}, 64'(carry64), 64'(m64[64]));
    if (use64) begin
      check({tag, "_k64"}, val64, ev64);
      check({tag, "_kc64"}, 64'(carry64), 64'(ec64));
    end
    @(posedge clk); #1;
  endtask

  // Streams req_q through both instances; scoreboard check of every result.
  task automatic run(input string tag, input int max_cyc, input bit rnd,
                     input int stall_from, input int stall_len, input bit chk_full);
    int          cyc;
    bit          held;
    logic [31:0] hv;
    logic        hc;
    logic [64:0] e;
    cyc  = 0;
    held = 1'b0;
    hv   = '0;
    hc   = 1'b0;
    while ((req_q.size() > 0 || exp32_q.size() > 0 || exp64_q.size() > 0) && cyc < max_cyc) begin
      if (req_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        drive(req_q[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      else     out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      @(negedge clk);
      if (held) begin
        check({tag, "_hold_ov"}, 64'(out_valid32), 64'd1);
        check({tag, "_hold_v"}, 64'(val32), 64'(hv));
        check({tag, "_hold_c"}, 64'(carry32), 64'(hc));
      end
      if (chk_full && !out_ready) check({tag, "_inrdy_full"}, 64'(in_ready32), 64'd0);
      if (in_valid && in_ready64) exp64_q.push_back(model(64, req_q[0]));
      if (in_valid && in_ready32) begin
        exp32_q.push_back(model(32, req_q[0]));
        void'(req_q.pop_front());
      end
      if (out_valid32 && out_ready) begin
        if (exp32_q.size() == 0) check({tag, "_extra32"}, 64'd1, 64'd0);
        else begin
          e = exp32_q.pop_front();
          check({tag, "_v32"}, 64'(val32), e[63:0]);
          check({tag, "_c32"}, 64'(carry32), 64'(e[64]));
        end
      end
      if (out_valid64 && out_ready) begin
        if (exp64_q.size() == 0) check({tag, "_extra64"}, 64'd1, 64'd0);
        else begin
          e = exp64_q.pop_front();
          check({tag, "_v64"}, val64, e[63:0]);
          check({tag, "_c64"}, 64'(carry64), 64'(e[64]));
        end
      end
      held = out_valid32 && !out_ready;
      hv   = val32;
      hc   = carry32;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_drain"}, 64'(req_q.size() + exp32_q.size() + exp64_q.size()), 64'd0);
    req_q.delete();
    exp32_q.delete();
    exp64_q.delete();
  endtask

  // Fill both stages (S2 = a, S1 = b) with the consumer stalled.
  task automatic fill2(input req_t a, input req_t b);
    out_ready = 1'b0;
    drive(a);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 0, 12'h0, 64'h0, 8'h0, 0));
    #12;
    // reset state
    check("rst_ov32", 64'(out_valid32), 64'd0);
    check("rst_v32", 64'(val32), 64'd0);
    check("rst_c32", 64'(carry32), 64'd0);
    check("rst_ov64", 64'(out_valid64), 64'd0);
    check("rst_inrdy", 64'(in_ready32), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // rotated immediate
    single("imm_rot", mk(0, 1, 0, 12'h4FF, 64'h1234, 8'h0, 0), 32'hFF00_0000, 1'b1,
           1, 64'hFF00_0000_0000_0000, 1'b1);
    // immediate shifts
    single("lsr0", mk(0, 0, 0, 12'h020, 64'h8000_0001, 8'h0, 0), 32'h0, 1'b1, 0, 64'h0, 1'b0);
    single("rrx", mk(0, 0, 0, 12'h060, 64'h3, 8'h0, 1), 32'h8000_0001, 1'b1, 0, 64'h0, 1'b0);
    single("asr4", mk(0, 0, 0, 12'h240, 64'hF000_0010, 8'h0, 0), 32'hFF00_0001, 1'b0,
           1, 64'h0F00_0001, 1'b0);
    // register-shift boundaries
    single("lsl32", mk(0, 0, 1, 12'h000, 64'h8000_0001, 8'd32, 0), 32'h0, 1'b1, 0, 64'h0, 1'b0);
    single("lsl33", mk(0, 0, 1, 12'h000, 64'h8000_0001, 8'd33, 1), 32'h0, 1'b0, 0, 64'h0, 1'b0);
    single("ror64", mk(0, 0, 1, 12'h060, 64'h8000_0001, 8'd64, 0), 32'h8000_0001, 1'b1,
           1, 64'h8000_0001, 1'b0);
    single("lsr_r0", mk(0, 0, 1, 12'h020, 64'h8000_0001, 8'd0, 1), 32'h8000_0001, 1'b1, 0, 64'h0, 1'b0);
    // memory offset beats immediate
    single("mem_c1", mk(1, 1, 1, 12'hABC, 64'hFFFF, 8'd5, 1), 32'h0000_0ABC, 1'b1,
           1, 64'h0ABC, 1'b1);
    single("mem_c0", mk(1, 1, 0, 12'hABC, 64'hFFFF, 8'd5, 0), 32'h0000_0ABC, 1'b0, 0, 64'h0, 1'b0);
    // wide register LSR
    single("lsr63", mk(0, 0, 1, 12'h020, 64'h8000_0000_0000_0000, 8'd63, 0), 32'h0, 1'b0,
           1, 64'h1, 1'b0);

    // backpressure: 4 back-to-back, consumer stalled 3 cycles once both stages are full
    for (int i = 0; i < 4; i++) req_q.push_back(rnd_req());
    run("bp", 60, 0, 2, 3, 1);

    // flush with two requests in flight
    fill2(mk(0, 0, 1, 12'h000, 64'h5, 8'd1, 0), mk(1, 0, 0, 12'h123, 64'h0, 8'd0, 1));
    check("fl_pre_ov", 64'(out_valid32), 64'd1);
    flush = 1'b1;
    drive(mk(1, 0, 0, 12'h777, 64'h0, 8'd0, 1));
    in_valid = 1'b1;
    @(negedge clk);
    check("fl_inrdy32", 64'(in_ready32), 64'd0);
    check("fl_inrdy64", 64'(in_ready64), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_ov32", 64'(out_valid32), 64'd0);
    check("fl_ov64", 64'(out_valid64), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("fl_noacc", 64'(out_valid32), 64'd0);

    // asynchronous reset with two requests in flight
    fill2(mk(1, 0, 0, 12'hABC, 64'h0, 8'd0, 1), mk(1, 0, 0, 12'h456, 64'h0, 8'd0, 1));
    check("ar_pre_v", 64'(val32), 64'h0ABC);
    check("ar_pre_c", 64'(carry32), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_ov32", 64'(out_valid32), 64'd0);
    check("ar_v32", 64'(val32), 64'd0);
    check("ar_c32", 64'(carry32), 64'd0);
    check("ar_ov64", 64'(out_valid64), 64'd0);
    check("ar_v64", val64, 64'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ar_lost", 64'(out_valid32), 64'd0);

    // randomized stream with random gaps and random backpressure
    for (int i = 0; i < 60; i++) req_q.push_back(rnd_req());
    run("rnd", 2000, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
